// File: rtl/shared_or_arbiter.sv
// shared_or_arbiter: round-robin arbiter feeding one shared WIDTH-bit OR unit
// into a single-entry result register with valid/ready handshake.
// Optional build macro SHARED_OR_ARBITER_STATS_EN adds a saturating 16-bit
// op_count output that counts accepted operations.
module shared_or_arbiter #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  input  logic                  rsp_ready
`ifdef SHARED_OR_ARBITER_STATS_EN
  ,
  output logic [15:0]           op_count
`endif
);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   ptr_next;
  logic             any_valid;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] or_result;

  // Circular search from rr_ptr upward; iterating from the farthest offset
  // down lets the nearest valid requester overwrite earlier candidates.
  always_comb begin
    int           idx;
    logic [IDW-1:0] idx_w;
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (req_valid[idx_w]) begin
        grant     = idx_w;
        any_valid = 1'b1;
      end
    end
  end

  // Reset is folded in so nothing is offered while the block is held in reset.
  assign slot_free = !rsp_valid || rsp_ready;
  assign accept    = slot_free && any_valid && ASYNCRESETN;
  assign ptr_next  = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

  // One-hot acceptance toward the granted requester only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant == IDW'(i));
    end
  end

  // Operands are steered to the single shared OR unit.
  assign a_sel     = req_a[grant*WIDTH +: WIDTH];
  assign b_sel     = req_b[grant*WIDTH +: WIDTH];
  assign or_result = a_sel | b_sel;

  // Result register and round-robin pointer; accept wins over drain.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= or_result;
      rsp_id    <= grant;
      rr_ptr    <= ptr_next;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef SHARED_OR_ARBITER_STATS_EN
  // Accept counter that sticks at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      op_count <= '0;
    end else if (accept && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule
